// File: rtl/approx_mul_err_monitor_pkg.sv
// -----------------------------------------------------------------------------
// approx_mul_err_monitor_pkg
//
// Shared definitions for the approximate-multiplier error monitor:
//   - OPW / PW      : operand and product widths of the monitored multiplier
//   - state_t       : window-control FSM states
//   - res_rec_t     : one result record (error count / error sum / worst case),
//                     sized as a container wide enough for any legal
//                     configuration of the monitor
//   - DRAIN_CYCLES  : number of cycles the FSM waits after the last beat so
//                     the datapath pipeline has emptied into the accumulators
//   - max_pw()      : unsigned maximum of two product-width values
// -----------------------------------------------------------------------------
package approx_mul_err_monitor_pkg;

    localparam int OPW = 8;
    localparam int PW  = 2 * OPW;

    // Two datapath stages plus the accumulate register.
    localparam int DRAIN_CYCLES = 3;

    localparam int REC_CNT_W = 32;
    localparam int REC_SUM_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [REC_CNT_W-1:0] cnt;
        logic [REC_SUM_W-1:0] sum;
        logic [PW-1:0]        max;
    } res_rec_t;

    function automatic logic [PW-1:0] max_pw(input logic [PW-1:0] a,
                                             input logic [PW-1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/approx_mul_err_monitor_err_dist_stage.sv
// -----------------------------------------------------------------------------
// err_dist_stage
//
// Two-stage pipeline that scores one multiplier beat: it recomputes the exact
// unsigned product of x and y and produces the error distance |z - x*y|
// together with a flag that is set whenever the distance is non-zero.
//
//   Stage 1: register the operands, the approximate product and the valid bit.
//   Stage 2: exact product, signed subtract one bit wider than the product,
//            magnitude, registered as diff / flag with diff_valid.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   valid        input beat valid (already qualified by the handshake)
//   x, y         multiplier operands, OPW bits each
//   z            approximate product, 2*OPW bits
//   diff_valid   diff / flag hold a scored beat this cycle
//   diff         |z - x*y|, 2*OPW bits
//   flag         diff != 0
//   pending      a beat is still travelling through either stage
// -----------------------------------------------------------------------------
module err_dist_stage #(
    parameter int OPW = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               valid,
    input  logic [OPW-1:0]     x,
    input  logic [OPW-1:0]     y,
    input  logic [2*OPW-1:0]   z,
    output logic               diff_valid,
    output logic [2*OPW-1:0]   diff,
    output logic               flag,
    output logic               pending
);

    localparam int PW = 2 * OPW;

    logic           s1_valid;
    logic [OPW-1:0] s1_x;
    logic [OPW-1:0] s1_y;
    logic [PW-1:0]  s1_z;

    logic [PW-1:0]        exact;
    logic signed [PW:0]   delta;
    logic [PW-1:0]        mag;

    // Valid bits carry the pipeline state and must come out of reset empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            diff_valid <= 1'b0;
        end else begin
            s1_valid   <= valid;
            diff_valid <= s1_valid;
        end
    end

    // NOTE: payload registers are deliberately left without reset; they are
    // only ever consumed under their valid bit, so clearing them buys nothing.
    always_ff @(posedge clk) begin
        if (valid) begin
            s1_x <= x;
            s1_y <= y;
            s1_z <= z;
        end
        if (s1_valid) begin
            diff <= mag;
            flag <= (mag != '0);
        end
    end

    // The subtract is one bit wider than the product so a product larger
    // than z shows up as a negative value rather than wrapping; the magnitude
    // then always fits back into PW bits.
    // NOTE: every variable assigned here gets a value on every path, so no
    // latch can be inferred.
    always_comb begin
        exact = PW'(s1_x) * PW'(s1_y);
        delta = $signed({1'b0, s1_z}) - $signed({1'b0, exact});
        mag   = delta[PW] ? PW'(-delta) : PW'(delta);
    end

    assign pending = s1_valid | diff_valid;

endmodule

// File: rtl/approx_mul_err_monitor.sv
// -----------------------------------------------------------------------------
// approx_mul_err_monitor
//
// Streaming error-statistics stage for an approximate unsigned OPWxOPW
// multiplier. A window of n_samples beats (0 counts as 1) is accepted after a
// start pulse; each beat is scored by err_dist_stage and folded into three
// accumulators. When the pipeline has drained, one result record is presented
// and held until res_ready.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        one-cycle pulse, honoured only in IDLE
//   n_samples    window length, CNT_W bits
//   in_valid     input beat valid
//   in_ready     registered; high in RUN while the window still needs beats
//   x, y, z      operands and approximate product of the multiplier
//   res_valid    result record valid (DONE)
//   res_ready    result consumer ready
//   err_cnt      number of beats with z != x*y
//   err_sum      saturating sum of |z - x*y|
//   err_max      largest |z - x*y| seen in the window
//   busy         high in RUN or DRAIN
// -----------------------------------------------------------------------------
module approx_mul_err_monitor
    import approx_mul_err_monitor_pkg::*;
#(
    parameter int N_MAX = 65535,
    parameter int SUM_W = 32,
    parameter int CNT_W = $clog2(N_MAX + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] n_samples,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   x,
    input  logic [OPW-1:0]   y,
    input  logic [PW-1:0]    z,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CNT_W-1:0] err_cnt,
    output logic [SUM_W-1:0] err_sum,
    output logic [PW-1:0]    err_max,
    output logic             busy
);

    state_t           state;
    logic [CNT_W-1:0] win_len;
    logic [CNT_W-1:0] beat_cnt;
    logic [1:0]       drain_cnt;

    logic             accept;
    logic             diff_valid;
    logic [PW-1:0]    diff;
    logic             flag;
    logic             pending;
    logic [SUM_W:0]   sum_ext;

    assign accept = in_valid & in_ready;

    err_dist_stage #(
        .OPW (OPW)
    ) u_err_dist (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid      (accept),
        .x          (x),
        .y          (y),
        .z          (z),
        .diff_valid (diff_valid),
        .diff       (diff),
        .flag       (flag),
        .pending    (pending)
    );

    // Window control. in_ready, res_valid and busy are registered alongside
    // the state so none of them depends combinationally on the inputs.
    // NOTE: sequential state is written with non-blocking assignments only, so
    // every register here samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b0;
            res_valid <= 1'b0;
            busy      <= 1'b0;
            win_len   <= '0;
            beat_cnt  <= '0;
            drain_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        win_len  <= (n_samples == '0) ? CNT_W'(1) : n_samples;
                        beat_cnt <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                        if (beat_cnt + CNT_W'(1) == win_len) begin
                            in_ready  <= 1'b0;
                            drain_cnt <= '0;
                            state     <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Fixed-length drain covering S1, S2 and the accumulate
                    // register; the pending check keeps it honest if the
                    // pipeline is ever deepened.
                    drain_cnt <= drain_cnt + 2'd1;
                    if (drain_cnt == 2'(DRAIN_CYCLES - 1) && !pending) begin
                        res_valid <= 1'b1;
                        busy      <= 1'b0;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Saturating add: one extra bit catches the carry out of the sum.
    assign sum_ext = {1'b0, err_sum} + (SUM_W + 1)'(diff);

    // Accumulators are cleared only by reset or by an accepted start, so the
    // last result remains readable after the record has been consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
            err_sum <= '0;
            err_max <= '0;
        end else if (state == ST_IDLE && start) begin
            err_cnt <= '0;
            err_sum <= '0;
            err_max <= '0;
        end else if (diff_valid) begin
            err_cnt <= err_cnt + CNT_W'(flag);
            err_sum <= sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
            err_max <= max_pw(err_max, diff);
        end
    end

endmodule

// File: tb/tb_approx_mul_err_monitor.sv
// -----------------------------------------------------------------------------
// tb_approx_mul_err_monitor
//
// Drives two monitors in parallel from the same stimulus: the default
// configuration (SUM_W=32) and a narrow one (SUM_W=16) whose error sum
// saturates early. A small reference model scores every beat; the expected
// record of each window is pushed to a queue when the window's beats are
// driven and popped when the DUT raises res_valid.
// -----------------------------------------------------------------------------
module tb_approx_mul_err_monitor;
    import approx_mul_err_monitor_pkg::*;

    localparam int CNT_W = 16;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [CNT_W-1:0] n_samples;
    logic             in_valid;
    logic [OPW-1:0]   x;
    logic [OPW-1:0]   y;
    logic [PW-1:0]    z;
    logic             res_ready;

    logic             in_ready,  s16_in_ready;
    logic             res_valid, s16_res_valid;
    logic             busy,      s16_busy;
    logic [CNT_W-1:0] err_cnt,   s16_err_cnt;
    logic [31:0]      err_sum;
    logic [15:0]      s16_err_sum;
    logic [PW-1:0]    err_max,   s16_err_max;

    int total = 0;
    int bad   = 0;

    int      m_cnt;
    longint  m_s32;
    longint  m_s16;
    int      m_max;
    res_rec_t q32[$];
    res_rec_t q16[$];

    approx_mul_err_monitor #(.N_MAX(65535), .SUM_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .n_samples(n_samples),
        .in_valid(in_valid), .in_ready(in_ready), .x(x), .y(y), .z(z),
        .res_valid(res_valid), .res_ready(res_ready), .err_cnt(err_cnt),
        .err_sum(err_sum), .err_max(err_max), .busy(busy)
    );

    approx_mul_err_monitor #(.N_MAX(65535), .SUM_W(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start), .n_samples(n_samples),
        .in_valid(in_valid), .in_ready(s16_in_ready), .x(x), .y(y), .z(z),
        .res_valid(s16_res_valid), .res_ready(res_ready), .err_cnt(s16_err_cnt),
        .err_sum(s16_err_sum), .err_max(s16_err_max), .busy(s16_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, want);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_in_ready"},  64'(in_ready),    0);
        check({tag, "_res_valid"}, 64'(res_valid),   0);
        check({tag, "_busy"},      64'(busy),        0);
        check({tag, "_cnt"},       64'(err_cnt),     0);
        check({tag, "_sum"},       64'(err_sum),     0);
        check({tag, "_max"},       64'(err_max),     0);
        check({tag, "_s16_rv"},    64'(s16_res_valid), 0);
        check({tag, "_s16_sum"},   64'(s16_err_sum), 0);
    endtask

    task automatic model_clear();
        m_cnt = 0;
        m_s32 = 0;
        m_s16 = 0;
        m_max = 0;
    endtask

    task automatic model_beat(input int bx, input int by, input int bz);
        int d;
        d = bz - bx * by;
        if (d < 0) d = -d;
        if (d != 0) m_cnt++;
        m_s32 = m_s32 + d;
        if (m_s32 > 64'hFFFF_FFFF) m_s32 = 64'hFFFF_FFFF;
        m_s16 = m_s16 + d;
        if (m_s16 > 65535) m_s16 = 65535;
        if (d > m_max) m_max = d;
    endtask

    task automatic push_expected();
        res_rec_t r;
        r.cnt = 32'(m_cnt);
        r.sum = 32'(m_s32);
        r.max = 16'(m_max);
        q32.push_back(r);
        r.sum = 32'(m_s16);
        q16.push_back(r);
    endtask

    // Called at a negedge; returns at a negedge with in_ready expected high.
    task automatic do_start(input int n);
        start     = 1'b1;
        n_samples = CNT_W'(n);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("start_in_ready", 64'(in_ready), 1);
        check("start_busy",     64'(busy),     1);
        model_clear();
    endtask

    // Offers one beat and waits (bounded) until it is accepted.
    task automatic send_beat(input int bx, input int by, input int bz);
        int guard = 0;
        in_valid = 1'b1;
        x = OPW'(bx);
        y = OPW'(by);
        z = PW'(bz);
        while (in_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) check("beat_accept_timeout", 64'(in_ready), 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        model_beat(bx, by, bz);
    endtask

    // Entered at the negedge right after the last accepted beat (cycle t+1).
    task automatic wait_result(output int lat);
        check("drain_in_ready", 64'(in_ready), 0);
        lat = 1;
        while (res_valid !== 1'b1 && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        check("res_valid",     64'(res_valid),     1);
        check("s16_res_valid", 64'(s16_res_valid), 1);
    endtask

    task automatic compare_result(input string tag);
        res_rec_t e32, e16;
        check({tag, "_sb_nonempty"}, 64'(q32.size() != 0 && q16.size() != 0), 1);
        if (q32.size() != 0 && q16.size() != 0) begin
            e32 = q32.pop_front();
            e16 = q16.pop_front();
            check({tag, "_cnt"},     64'(err_cnt),     64'(e32.cnt));
            check({tag, "_sum"},     64'(err_sum),     64'(e32.sum));
            check({tag, "_max"},     64'(err_max),     64'(e32.max));
            check({tag, "_s16_cnt"}, 64'(s16_err_cnt), 64'(e16.cnt));
            check({tag, "_s16_sum"}, 64'(s16_err_sum), 64'(e16.sum));
            check({tag, "_s16_max"}, 64'(s16_err_max), 64'(e16.max));
        end
    endtask

    task automatic handshake();
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        check("hs_res_valid", 64'(res_valid), 0);
        check("hs_in_ready",  64'(in_ready),  0);
        check("hs_busy",      64'(busy),      0);
    endtask

    initial begin
        int lat;
        res_rec_t hold;

        rst_n     = 1'b0;
        start     = 1'b0;
        n_samples = '0;
        in_valid  = 1'b0;
        x         = '0;
        y         = '0;
        z         = '0;
        res_ready = 1'b0;
        model_clear();

        // Reset state.
        repeat (3) @(negedge clk);
        check_idle_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_idle_zero("post_reset");

        // Exact products only: all metrics zero, res_valid at t+4.
        do_start(4);
        send_beat(255, 255, 65025);
        send_beat(3, 5, 15);
        send_beat(0, 200, 0);
        send_beat(16, 16, 256);
        push_expected();
        wait_result(lat);
        check("latency", 64'(lat), 4);
        compare_result("exact");
        handshake();

        // Three erroneous beats.
        do_start(3);
        send_beat(3, 5, 14);
        send_beat(200, 200, 40100);
        send_beat(255, 255, 0);
        push_expected();
        wait_result(lat);
        compare_result("errs");
        handshake();

        // n=0 behaves as a one-beat window.
        do_start(0);
        send_beat(2, 2, 5);
        push_expected();
        wait_result(lat);
        compare_result("n0");
        handshake();

        // Sum saturation on the narrow instance.
        do_start(3);
        send_beat(255, 255, 0);
        send_beat(255, 255, 0);
        send_beat(255, 255, 0);
        push_expected();
        wait_result(lat);
        compare_result("sat");
        handshake();

        // Gapped input with junk on idle cycles, then a long result stall.
        do_start(4);
        send_beat(10, 10, 99);
        x = 8'hFF; y = 8'hFF; z = 16'h0000;
        @(negedge clk);
        send_beat(7, 9, 63);
        x = 8'hFF; y = 8'hFF; z = 16'h0000;
        @(negedge clk);
        send_beat(100, 3, 290);
        x = 8'hFF; y = 8'hFF; z = 16'h0000;
        @(negedge clk);
        send_beat(255, 1, 254);
        push_expected();
        wait_result(lat);
        hold = q32[0];
        compare_result("stall");
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin
                start     = 1'b1;
                n_samples = CNT_W'(2);
            end
            @(negedge clk);
            start = 1'b0;
            check("stall_res_valid", 64'(res_valid), 1);
            check("stall_in_ready",  64'(in_ready),  0);
            check("stall_cnt",       64'(err_cnt),   64'(hold.cnt));
            check("stall_sum",       64'(err_sum),   64'(hold.sum));
            check("stall_max",       64'(err_max),   64'(hold.max));
        end
        // start coinciding with the DONE handshake is ignored too.
        start     = 1'b1;
        n_samples = CNT_W'(2);
        handshake();
        start = 1'b0;
        @(negedge clk);
        check("post_hs_in_ready", 64'(in_ready), 0);
        check("post_hs_busy",     64'(busy),     0);
        check("post_hs_cnt_kept", 64'(err_cnt),  64'(hold.cnt));
        check("post_hs_sum_kept", 64'(err_sum),  64'(hold.sum));

        // Reset in the middle of a window discards it.
        do_start(5);
        send_beat(3, 3, 1);
        send_beat(4, 4, 2);
        rst_n = 1'b0;
        #1;
        check_idle_zero("midrun_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_zero("after_rst");

        do_start(1);
        send_beat(1, 1, 1);
        push_expected();
        wait_result(lat);
        compare_result("fresh");
        handshake();

        check("sb_drained", 64'(q32.size() + q16.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/approx_mul_err_monitor.md
# approx_mul_err_monitor

Streaming error-statistics stage placed directly downstream of an approximate unsigned 8x8 multiplier. Each accepted beat carries the multiplier's operands and its 16-bit approximate product. The block recomputes the exact product, accumulates error metrics over a programmed window of samples, and presents one result record per window. Characterisation benches and the on-chip self-test both use it to score multiplier variants (error rate, mean error distance, worst case).

## Interface
- `N_MAX`, 65535: largest window length; sets `CNT_W = $clog2(N_MAX+1)`.
- `SUM_W`, 32: width of the error-distance accumulator; must be ≥ 16 + `CNT_W`.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse; latches `n_samples` and begins a window (IDLE only).
- `n_samples`  in  `CNT_W`  window length; 0 is treated as 1.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  input beat accepted when `in_valid & in_ready`.
- `x`, `y`  in  8 each  operands given to the multiplier.
- `z`  in  16  approximate product from the multiplier.
- `res_valid`  out  1  result record valid.
- `res_ready`  in  1  result consumed when `res_valid & res_ready`.
- `err_cnt`  out  `CNT_W`  number of samples with `z != x*y`.
- `err_sum`  out  `SUM_W`  sum of |z − x*y|.
- `err_max`  out  16  maximum |z − x*y|.
- `busy`  out  1  high in RUN or DRAIN.

## Operation
- FSM states: IDLE → RUN → DRAIN → DONE → IDLE.
- IDLE: `in_ready`=0. On `start`, load the window length (`n_samples`, with 0 forced to 1), clear the accumulators and go to RUN.
- RUN: `in_ready`=1 while accepted count < window length. When the last beat is accepted, go to DRAIN.
- DRAIN: wait until the pipeline holds no valid beats, then go to DONE.
- DONE: `res_valid`=1 and the outputs hold stable. On `res_ready`, go to IDLE. Accumulators keep their values until the next `start`.
- Datapath, stage 1: register x, y, z and the valid bit. Stage 2: form exact = x*y (16 bit, unsigned). Form diff = |z − exact| using a 17-bit signed subtract, then take the magnitude; max value 65535. Register diff and the flag (diff≠0).
- Accumulate stage: on each valid stage-2 beat, apply all three updates:
  - `err_cnt` += flag
  - `err_sum` += diff, saturating at all-ones
  - `err_max` = max(`err_max`, diff)
- `start` outside IDLE is ignored. `start` in the same cycle as a DONE handshake is also ignored.
- `in_valid` without `in_ready` has no effect. x, y and z are don't-care when `in_valid`=0.
- `rst_n` low at any time: the FSM goes to IDLE and all outputs and accumulators clear. A partial window is discarded and no result is produced.

## Timing
- Reset values: `in_ready`=0, `res_valid`=0, `busy`=0, `err_cnt`=0, `err_sum`=0, `err_max`=0.
- Throughput: 1 beat/cycle in RUN, no bubbles required.
- Input-to-accumulator latency: 3 cycles (S1, S2, accumulate register).
- Last beat accepted at cycle t: `res_valid` rises at cycle t+4 at the earliest. DRAIN lasts exactly 3 cycles.
- `in_ready` is a registered FSM/count decode and does not depend combinationally on `in_valid`.
- `start` accepted at cycle t: `in_ready`=1 at cycle t+1.
- `res_valid` holds until `res_ready` is sampled high. After the handshake, `in_ready` stays 0 for at least one cycle (IDLE).

## Structure
- A shared package holds:
  - the FSM state enum (`ST_IDLE`, `ST_RUN`, `ST_DRAIN`, `ST_DONE`)
  - the result record struct (cnt/sum/max)
  - the `OPW`=8 and `PW`=16 constants
- Sub-module `err_dist_stage`: a 2-stage pipeline with valid in/out, taking x, y, z and producing diff and flag. It is reusable for other multiplier widths via `OPW`.
- Top level: FSM, beat counter, accumulators, handshake logic.

## Test plan
- Window n=4 with beats (255,255,65025), (3,5,15), (0,200,0), (16,16,256) → `err_cnt`=0, `err_sum`=0, `err_max`=0. `res_valid` rises 4 cycles after the last accept.
- Window n=3 with beats (3,5,14), (200,200,40100), (255,255,0) → `err_cnt`=3, `err_sum`=1+100+65025=65126, `err_max`=65025.
- Window n=0 → behaves as n=1. Beat (2,2,5) → `err_cnt`=1, `err_sum`=1, `err_max`=1.
- `SUM_W`=16, n=3, three beats with diff 65025 each → `err_sum`=65535 (saturated), `err_cnt`=3.
- `in_valid` toggling every other cycle, `res_ready` held low for 10 cycles → results correct, outputs stable across the whole stall. A `start` pulse during DONE is ignored.
- `rst_n` asserted mid-RUN after 2 of 5 beats → all outputs 0 immediately. A fresh `start` with n=1, beat (1,1,1) → `err_cnt`=0.
